// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the six-digit display scanner.
package disp_pkg;
   localparam int NUM_DIGITS = 6;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   // Indexed by BCD value; codes 10..15 are blank so the decoder needs no range check.
   localparam logic [15:0][6:0] SEG_TABLE = {
      {6{SEG_BLANK}},
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
   typedef enum logic [1:0] {ADJ_NONE, ADJ_HOUR, ADJ_MIN, ADJ_SEC} adj_t;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD to active-low seven-segment {g,f,e,d,c,b,a}; blank for values >= 10.
module seg7_dec
   import disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   assign seg = SEG_TABLE[bcd];
endmodule

// File: rtl/disp_scan6.sv
// disp_scan6: six-digit multiplexed 7-seg scanner with frame shadowing, guard time and LZB.
// Field blinking of the adjusted field is built only when DISP_BLINK_EN is defined.
module disp_scan6
   import disp_pkg::*;
#(
   parameter int DIV          = 50000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 83,
   parameter int HOUR_LZB     = 1
) (
   input  logic       CP,
   input  logic       CR,
   input  logic [3:0] hh,
   input  logic [3:0] hl,
   input  logic [3:0] mh,
   input  logic [3:0] ml,
   input  logic [3:0] sh,
   input  logic [3:0] sl,
   input  logic [1:0] adj_sel,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] dig_n
);
   localparam int DW = $clog2(DIV);

   logic [DW-1:0] div_cnt;
   logic [2:0] idx;
   logic [NUM_DIGITS-1:0][3:0] shd;
   logic tick, frame, blink, lzb, guard;
   logic [6:0] dec;

   assign tick  = div_cnt == DW'(DIV - 1);
   assign frame = tick && idx == 3'(NUM_DIGITS - 1);
   assign guard = div_cnt < DW'(GUARD);
   assign lzb   = HOUR_LZB != 0 && idx == 3'd0 && shd[0] == 4'd0;

   always_ff @(posedge CP)
      if (CR) begin
         div_cnt <= '0;
         idx     <= '0;
         shd     <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) idx <= frame ? 3'd0 : idx + 3'd1;
         // Inputs are captured only at the frame boundary so a frame never tears.
         if (frame) shd <= {sl, sh, ml, mh, hl, hh};
      end

`ifdef DISP_BLINK_EN
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] frame_cnt;
   logic phase;

   always_ff @(posedge CP)
      if (CR) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (frame) begin
         frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
      end

   // Fields pair up slots: hour 0-1, minute 2-3, second 4-5.
   assign blink = phase && adj_t'(adj_sel) != ADJ_NONE && idx[2:1] == adj_sel - 2'd1;
`else
   logic unused_blink;
   assign unused_blink = ^{adj_sel, BLINK_FRAMES[0]};
   assign blink = 1'b0;
`endif

   seg7_dec u_dec (
      .bcd(shd[idx]),
      .seg(dec)
   );

   always_ff @(posedge CP)
      if (CR) begin
         seg_n <= SEG_BLANK;
         dp_n  <= 1'b1;
         dig_n <= '1;
      end else begin
         seg_n <= (blink || lzb) ? SEG_BLANK : dec;
         dp_n  <= blink || !(idx == 3'd1 || idx == 3'd3);
         dig_n <= guard ? 6'h3F : ~(6'd1 << idx);
      end
endmodule

// File: tb/tb_disp_scan6.sv
// tb_disp_scan6: directed checks of disp_scan6 with DIV=4, GUARD=1, BLINK_FRAMES=2, HOUR_LZB=1.
// Blink expectations follow DISP_BLINK_EN as defined for the build.
module tb_disp_scan6;
`ifdef DISP_BLINK_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   logic CP = 1'b0, CR = 1'b1;
   logic [3:0] hh, hl, mh, ml, sh, sl;
   logic [1:0] adj_sel;
   logic [6:0] seg_n;
   logic dp_n;
   logic [5:0] dig_n;
   int total = 0, bad = 0, k = 0;

   disp_scan6 #(.DIV(4), .GUARD(1), .BLINK_FRAMES(2), .HOUR_LZB(1)) dut (
      .CP(CP), .CR(CR), .hh(hh), .hl(hl), .mh(mh), .ml(ml), .sh(sh), .sl(sl),
      .adj_sel(adj_sel), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n)
   );

   always #5 CP = ~CP;

   task automatic step;
      @(posedge CP);
      #1;
      k++;
   endtask

   // After step k, outputs reflect the state of cycle k-1: frame f, slot j, offset o.
   task automatic goto(input int f, input int j, input int o);
      int tgt = 24 * f + 4 * j + o;
      int n = 0;
      while (k - 1 < tgt && n < 5000) begin
         step();
         n++;
      end
      total++;
      if (k - 1 != tgt) begin
         bad++;
         $display("FAIL goto f%0d s%0d o%0d at=%0d want=%0d", f, j, o, k - 1, tgt);
      end
   endtask

   task automatic test_reset;
      {hh, hl, mh, ml, sh, sl} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      adj_sel = 2'd0;
      CR = 1'b1;
      repeat (3) @(posedge CP);
      #1;
      total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7f", seg_n); end
      total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", dp_n); end
      total++; if (dig_n !== 6'h3F) begin bad++; $display("FAIL rst_dig got=%h exp=3f", dig_n); end
      CR = 1'b0;
      k = 0;
      goto(0, 0, 0);
      total++; if (dig_n !== 6'h3F) begin bad++; $display("FAIL f0_guard dig=%h exp=3f", dig_n); end
      goto(0, 0, 1);
      total++; if (dig_n !== 6'h3E || seg_n !== 7'h7F) begin bad++; $display("FAIL f0_s0 dig=%h seg=%h exp=3e/7f", dig_n, seg_n); end
      goto(0, 1, 1);
      total++; if (seg_n !== 7'h40 || dp_n !== 1'b0) begin bad++; $display("FAIL f0_s1 seg=%h dp=%b exp=40/0", seg_n, dp_n); end
      goto(0, 5, 2);
      total++; if (seg_n !== 7'h40 || dig_n !== 6'h1F) begin bad++; $display("FAIL f0_s5 seg=%h dig=%h exp=40/1f", seg_n, dig_n); end
   endtask

   task automatic test_live_load;
      logic [6:0] exp_seg [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
      logic [5:0] exp_dig [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
      for (int j = 0; j < 6; j++) begin
         goto(1, j, 0);
         total++; if (dig_n !== 6'h3F || seg_n !== exp_seg[j]) begin bad++; $display("FAIL live_guard s%0d dig=%h seg=%h exp=3f/%h", j, dig_n, seg_n, exp_seg[j]); end
         goto(1, j, 1);
         total++; if (dig_n !== exp_dig[j] || seg_n !== exp_seg[j]) begin bad++; $display("FAIL live s%0d dig=%h seg=%h exp=%h/%h", j, dig_n, seg_n, exp_dig[j], exp_seg[j]); end
         total++; if (dp_n !== !(j == 1 || j == 3)) begin bad++; $display("FAIL live_dp s%0d dp=%b", j, dp_n); end
      end
   endtask

   task automatic test_tearing;
      goto(2, 2, 1);
      ml = 4'd9;
      goto(2, 3, 1);
      total++; if (seg_n !== 7'h19) begin bad++; $display("FAIL tear_same seg=%h exp=19", seg_n); end
      goto(3, 3, 1);
      total++; if (seg_n !== 7'h10) begin bad++; $display("FAIL tear_next seg=%h exp=10", seg_n); end
   endtask

   task automatic test_blank;
      hh = 4'd0;
      sl = 4'hA;
      goto(4, 0, 0);
      total++; if (dig_n !== 6'h3F || seg_n !== 7'h7F) begin bad++; $display("FAIL lzb_guard dig=%h seg=%h exp=3f/7f", dig_n, seg_n); end
      goto(4, 0, 1);
      total++; if (dig_n !== 6'h3E || seg_n !== 7'h7F) begin bad++; $display("FAIL lzb dig=%h seg=%h exp=3e/7f", dig_n, seg_n); end
      goto(4, 1, 1);
      total++; if (seg_n !== 7'h24 || dp_n !== 1'b0) begin bad++; $display("FAIL blank_s1 seg=%h dp=%b exp=24/0", seg_n, dp_n); end
      goto(4, 5, 1);
      total++; if (dig_n !== 6'h1F || seg_n !== 7'h7F) begin bad++; $display("FAIL bcd_a dig=%h seg=%h exp=1f/7f", dig_n, seg_n); end
   endtask

   task automatic test_blink;
      adj_sel = 2'd2;
      goto(5, 2, 1);
      total++; if (seg_n !== 7'h30) begin bad++; $display("FAIL blink_f5 seg=%h exp=30", seg_n); end
      goto(6, 1, 1);
      total++; if (seg_n !== 7'h24 || dp_n !== 1'b0) begin bad++; $display("FAIL blink_f6_s1 seg=%h dp=%b exp=24/0", seg_n, dp_n); end
      goto(6, 2, 1);
      total++; if (seg_n !== (BL ? 7'h7F : 7'h30) || dig_n !== 6'h3B) begin bad++; $display("FAIL blink_f6_s2 seg=%h dig=%h", seg_n, dig_n); end
      goto(6, 3, 2);
      total++; if (seg_n !== (BL ? 7'h7F : 7'h10) || dp_n !== BL) begin bad++; $display("FAIL blink_f6_s3 seg=%h dp=%b", seg_n, dp_n); end
      goto(6, 4, 1);
      total++; if (seg_n !== 7'h12) begin bad++; $display("FAIL blink_f6_s4 seg=%h exp=12", seg_n); end
      goto(7, 2, 3);
      total++; if (seg_n !== (BL ? 7'h7F : 7'h30)) begin bad++; $display("FAIL blink_f7_s2 seg=%h", seg_n); end
      goto(8, 2, 1);
      total++; if (seg_n !== 7'h30) begin bad++; $display("FAIL blink_f8 seg=%h exp=30", seg_n); end
      adj_sel = 2'd0;
   endtask

   task automatic test_mid_reset;
      goto(9, 4, 2);
      CR = 1'b1;
      step();
      total++; if (dig_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1) begin bad++; $display("FAIL mid_rst dig=%h seg=%h dp=%b", dig_n, seg_n, dp_n); end
      CR = 1'b0;
      k = 0;
      goto(0, 0, 0);
      total++; if (dig_n !== 6'h3F || seg_n !== 7'h7F) begin bad++; $display("FAIL mid_guard dig=%h seg=%h exp=3f/7f", dig_n, seg_n); end
      goto(0, 0, 1);
      total++; if (dig_n !== 6'h3E || seg_n !== 7'h7F) begin bad++; $display("FAIL mid_s0 dig=%h seg=%h exp=3e/7f", dig_n, seg_n); end
      goto(0, 1, 1);
      total++; if (dig_n !== 6'h3D || seg_n !== 7'h40 || dp_n !== 1'b0) begin bad++; $display("FAIL mid_s1 dig=%h seg=%h dp=%b", dig_n, seg_n, dp_n); end
      goto(1, 2, 1);
      total++; if (seg_n !== 7'h30) begin bad++; $display("FAIL mid_reload seg=%h exp=30", seg_n); end
   endtask

   initial begin
      test_reset();
      test_live_load();
      test_tearing();
      test_blank();
      test_blink();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
